instr_fetch_rv32i: RTL
======================

INSTR_FETCH_RV32I -- requirements
Module: instr_fetch_rv32i

Interface
REQ-001 The module SHALL have a parameter RESET_PC, default 32'h0000_0000, giving the word-aligned first fetch address after reset.
REQ-002 The module SHALL have a port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have a port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The module SHALL have a port imem_addr, output, 32 bits: the fetch PC driven to the synchronous instruction ROM.
REQ-005 The module SHALL have a port imem_rdata, input, 32 bits: the ROM data, valid exactly one cycle after imem_addr is presented; the ROM is always enabled.
REQ-006 The module SHALL have a port redirect_valid, input, 1 bit: a branch/jump redirect request, one cycle wide per request.
REQ-007 The module SHALL have a port redirect_pc, input, 32 bits: the redirect target address.
REQ-008 The module SHALL have a port out_valid, output, 1 bit: fetched instruction available.
REQ-009 The module SHALL have a port out_ready, input, 1 bit: downstream accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-010 The module SHALL have a port out_pc, output, 32 bits: the PC of the presented instruction.
REQ-011 The module SHALL have a port out_instr, output, 32 bits: the presented instruction word.
REQ-012 The module SHALL have a port misalign_err, output, 1 bit: sticky flag, set when a redirect target is not word-aligned.

Function
REQ-013 Internal state SHALL be: fetch PC fpc; in-flight tag {inflight_v, inflight_pc}; 2-entry FIFO of {pc, instr} with count 0..2.
REQ-014 An issue SHALL be allowed when count + inflight_v - pop <= 1, where pop = out_valid & out_ready.
REQ-015 imem_addr SHALL equal redirect_pc (low 2 bits forced to 0) when redirect_valid is high, and fpc otherwise.
REQ-016 On an issue, the module SHALL set inflight_v=1, set inflight_pc=imem_addr, and set fpc=imem_addr+4 (modulo 2^32: 32'hFFFF_FFFC wraps to 0).
REQ-017 With no issue and no redirect, fpc SHALL hold and inflight_v SHALL clear, so that imem_addr is stable.
REQ-018 In a cycle with inflight_v=1 and no redirect, the module SHALL push {inflight_pc, imem_rdata} into the FIFO.
REQ-019 out_valid SHALL be count!=0, and out_pc/out_instr SHALL present the FIFO head.
REQ-020 Latency SHALL be: issue in cycle N -> data in cycle N+1 -> out_valid in cycle N+2.
REQ-021 With out_ready held high, throughput SHALL be 1 instruction per cycle with no bubbles, in strictly sequential PC order.
REQ-022 out_pc/out_instr SHALL hold stable while out_valid=1 and out_ready=0; the FIFO SHALL never overflow or drop an entry.
REQ-023 Pushes that coincide with pops SHALL keep count unchanged and preserve order.
REQ-024 A redirect SHALL flush the FIFO (count=0), discard the response arriving that cycle, and issue redirect_pc unconditionally.
REQ-025 A pop in the redirect cycle SHALL still complete (the consumer took the head); no entry fetched before the redirect appears afterwards.
REQ-026 Redirect to last completion: the first out_valid with out_pc=redirect_pc SHALL occur 2 cycles after the redirect.
REQ-027 If redirect_pc[1:0]!=0, the module SHALL set misalign_err=1 (held until reset) and fetch at {redirect_pc[31:2],2'b00}.
REQ-028 Back-to-back redirects SHALL each flush; the last one wins.

Reset
REQ-029 While rst=1: fpc=RESET_PC, inflight_v=0, count=0, out_valid=0, misalign_err=0, out_pc=0, out_instr=0, imem_addr=RESET_PC.
REQ-030 The first cycle with rst=0 SHALL be an issue of RESET_PC; out_valid SHALL rise 2 cycles later.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight and buffered instructions immediately, with no spurious transfer after release.

Verification
REQ-032 Reset release with out_ready=1, ROM word i = 32'h1000_0000+i -> out_valid at cycle 2, then out_pc 0,4,8,... with instr 10000000,10000001,..., one per cycle.
REQ-033 out_ready=0 for 5 cycles after first valid -> count saturates at 2, imem_addr frozen, outputs hold PC 0; release -> PCs 0,4,8 with no gap or duplicate.
REQ-034 Redirect to 0x40 while FIFO holds PCs 0x8 and 0xC and out_ready=1 -> 0x8 pops that cycle, 0xC is never seen, the next transfer is 0x40 two cycles later, then 0x44.
REQ-035 Redirect to 0x22 -> misalign_err=1 and stays high; fetch starts at 0x20; after rst it is 0.
REQ-036 Redirect to 0xFFFF_FFF8 -> PCs FFFFFFF8, FFFFFFFC, 0, 4.
REQ-037 rst pulsed asynchronously mid-stream with random out_ready -> out_valid=0 immediately and stream restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_rv32i.sv
// RV32I fetch stage: issues PCs to a synchronous ROM and buffers the
// returned words in a 2-entry FIFO behind a valid/ready output.
module instr_fetch_rv32i #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        misalign_err
);

    logic [31:0] fpc;
    logic        inflight_v;
    logic [31:0] inflight_pc;

    logic [31:0] buf_pc    [2];
    logic [31:0] buf_instr [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight_v & ~redirect_valid;

    // Issue only if the FIFO can still absorb the response next cycle.
    assign occupancy = {1'b0, count} + {2'b00, inflight_v};
    assign issue     = redirect_valid
                     | (occupancy <= ({2'b00, pop} + 3'd1));

    assign imem_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : fpc;

    assign out_pc    = buf_pc[rd_ptr];
    assign out_instr = buf_instr[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc          <= RESET_PC;
            inflight_v   <= 1'b0;
            inflight_pc  <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            inflight_v <= issue;
            if (issue) begin
                inflight_pc <= imem_addr;
                fpc         <= imem_addr + 32'd4;
            end
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
        end
    end

    // A redirect drops both buffered words and the response in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]    <= 32'd0;
                buf_instr[i] <= 32'd0;
            end
        end else if (redirect_valid) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr]    <= inflight_pc;
                buf_instr[wr_ptr] <= imem_rdata;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
